keypad_scan_4x4: RTL and testbench

- Scans a 4x4 matrix keypad and returns one debounced hex key code per press.
- Input-side counterpart of the counter/7-segment display path: keys enter hex values, the display shows them.
- Output feeds counter and FND logic as a one-cycle key_valid strobe plus a 4-bit code.
- Single clock domain. Keypad row inputs are asynchronous and synchronised inside the block.

---
 rtl/keypad_pkg.sv | 45 ++++
 rtl/keypad_row_sync.sv | 32 +++
 rtl/keypad_scan_4x4.sv | 131 +++++++++++++
 tb/tb_keypad_scan_4x4.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
`default_nettype none
//============================================================================
// Module : keypad_pkg
// Brief  : Shared state encoding, constants and key map for the 4x4 keypad.
// Rev    : 1.0
//============================================================================
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } kp_state_t;

    localparam logic [3:0] COL_RESET = 4'b1110;
    localparam logic [3:0] ROWS_IDLE = 4'b1111;

    // Indexed by {row, col}; leftmost entry is index 15 (row 3, col 3).
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic [3:0] key_code(input logic [1:0] row_idx,
                                            input logic [1:0] col_idx);
        return KEY_MAP[{row_idx, col_idx}];
    endfunction

    // Lowest-numbered active-low row wins when several rows are pulled down.
    function automatic logic [1:0] lowest_low(input logic [3:0] rows);
        logic [1:0] idx;
        casez (rows)
            4'b???0: idx = 2'd0;
            4'b??01: idx = 2'd1;
            4'b?011: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_row_sync.sv
`default_nettype none
//============================================================================
// Module : keypad_row_sync
// Brief  : Two-flop synchroniser for the asynchronous keypad row inputs.
// Rev    : 1.0
//============================================================================
module keypad_row_sync
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] i_row,
    output logic [3:0] o_row_s
);

    logic [3:0] r_meta;
    logic [3:0] r_sync;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_meta <= ROWS_IDLE;
            r_sync <= ROWS_IDLE;
        end else begin
            r_meta <= i_row;
            r_sync <= r_meta;
        end
    end

    assign o_row_s = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_scan_4x4.sv
`default_nettype none
//============================================================================
// Module : keypad_scan_4x4
// Brief  : 4x4 matrix keypad scanner with press/release debounce.
// Rev    : 1.0
//============================================================================
module keypad_scan_4x4
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 500000,
    parameter int CNT_W        = 20
)(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_value,
    output logic       key_valid,
    output logic       key_down
);

    localparam logic [CNT_W-1:0] c_dwell_last = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] c_db_last    = CNT_W'(DEBOUNCE_CNT - 1);

    kp_state_t        r_state;
    kp_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_dwell;
    logic [CNT_W-1:0] r_db_cnt;
    logic [1:0]       r_col_idx;
    logic [1:0]       r_row_idx;
    logic [3:0]       r_pattern;
    logic [3:0]       r_key_value;
    logic             r_key_valid;
    logic             r_key_down;
    logic [3:0]       w_row_s;
    logic             w_dwell_end;
    logic             w_db_end;
    logic             w_hit;

    keypad_row_sync u_row_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_row   (row),
        .o_row_s (w_row_s)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_dwell_end = (r_dwell == c_dwell_last);
        w_db_end    = (r_db_cnt == c_db_last);
        w_hit       = (w_row_s != ROWS_IDLE);
        case (r_state)
            SCAN: begin
                if (w_dwell_end && w_hit)
                    w_state_nxt = PRESS_DB;
            end
            PRESS_DB: begin
                if (w_row_s != r_pattern)
                    w_state_nxt = SCAN;
                else if (w_db_end)
                    w_state_nxt = HELD;
            end
            HELD: begin
                if (!w_hit)
                    w_state_nxt = REL_DB;
            end
            REL_DB: begin
                if (w_hit)
                    w_state_nxt = HELD;
                else if (w_db_end)
                    w_state_nxt = SCAN;
            end
            default: w_state_nxt = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            r_state <= SCAN;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_dwell     <= '0;
            r_db_cnt    <= '0;
            r_col_idx   <= 2'd0;
            r_row_idx   <= 2'd0;
            r_pattern   <= ROWS_IDLE;
            r_key_value <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_down  <= 1'b0;
        end else begin
            // Dwell restarts from zero whenever SCAN is (re)entered.
            if (r_state == SCAN && !w_dwell_end)
                r_dwell <= r_dwell + 1'b1;
            else
                r_dwell <= '0;

            if (r_state == SCAN && w_dwell_end) begin
                if (w_hit) begin
                    r_pattern <= w_row_s;
                    r_row_idx <= lowest_low(w_row_s);
                end else begin
                    r_col_idx <= r_col_idx + 1'b1;
                end
            end

            // Counter stops at its terminal value; the state change clears it.
            if (w_state_nxt != r_state)
                r_db_cnt <= '0;
            else if ((r_state == PRESS_DB || r_state == REL_DB) && !w_db_end)
                r_db_cnt <= r_db_cnt + 1'b1;

            r_key_valid <= (r_state == PRESS_DB) && (w_state_nxt == HELD);
            if (r_state == PRESS_DB && w_state_nxt == HELD)
                r_key_value <= key_code(r_row_idx, r_col_idx);

            r_key_down <= (w_state_nxt == HELD) || (w_state_nxt == REL_DB);
        end
    end

    assign col       = ~(4'b0001 << r_col_idx);
    assign key_value = r_key_value;
    assign key_valid = r_key_valid;
    assign key_down  = r_key_down;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_4x4.sv
`default_nettype none
//============================================================================
// Module : tb_keypad_scan_4x4
// Brief  : Scoreboard bench for keypad_scan_4x4 with a modelled key matrix.
// Rev    : 1.0
//============================================================================
module tb_keypad_scan_4x4;

    logic       clk;
    logic       reset_n;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_value;
    logic       key_valid;
    logic       key_down;

    logic [15:0] pressed;     // bit r*4+c = key at (row r, col c) closed
    logic [3:0]  exp_q[$];
    int          n_checks;
    int          n_pass;

    keypad_scan_4x4 #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (8),
        .CNT_W        (20)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .row       (row),
        .col       (col),
        .key_value (key_value),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Matrix model: a closed key pulls its row low while its column is driven.
    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && col[c] == 1'b0)
                    row[r] = 1'b0;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every key_valid strobe must match the next queued key.
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_key_valid: got key %0h expected no strobe (t=%0t)",
                         key_value, $time);
            end else begin
                logic [3:0] exp_v;
                exp_v = exp_q.pop_front();
                check("key_valid_value", {4'h0, key_value}, {4'h0, exp_v});
            end
        end
    end

    task automatic wait_down(input logic lvl, input int max_cyc, input string name);
        for (int i = 0; i < max_cyc; i++) begin
            if (key_down === lvl) break;
            @(negedge clk);
        end
        check(name, {7'h0, key_down}, {7'h0, lvl});
    endtask

    task automatic wait_col(input logic [3:0] target);
        for (int i = 0; i < 40 && col === target; i++) @(negedge clk);
        for (int i = 0; i < 40 && col !== target; i++) @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        pressed  = '0;
        reset_n  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_col",       {4'h0, col},       8'h0E);
        check("reset_key_value", {4'h0, key_value}, 8'h00);
        check("reset_key_valid", {7'h0, key_valid}, 8'h00);
        check("reset_key_down",  {7'h0, key_down},  8'h00);

        // Column walk: four cycles per column after reset is released.
        reset_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            logic [3:0] exp_col;
            @(negedge clk);
            exp_col = ~(4'b0001 << ((k / 4) % 4));
            check("col_sequence", {4'h0, col}, {4'h0, exp_col});
        end

        // Clean press of "5" (row 1, col 1)
        pressed[1*4+1] = 1'b1;
        exp_q.push_back(4'h5);
        wait_down(1'b1, 60, "press5_key_down");
        check("press5_value", {4'h0, key_value}, 8'h05);
        repeat (25) @(negedge clk);
        check("press5_held_down", {7'h0, key_down}, 8'h01);
        pressed = '0;
        wait_down(1'b0, 20, "press5_release");
        for (int i = 0; i < 8 && col === 4'b1101; i++) @(negedge clk);
        check("scan_resumes", {4'h0, col}, 8'h0B);

        // Bounce on row 2 / col 3 too short to be accepted
        wait_col(4'b0111);
        pressed[2*4+3] = 1'b1;
        repeat (3) @(negedge clk);
        pressed = '0;
        repeat (6) @(negedge clk);
        check("bounce_key_down",  {7'h0, key_down},  8'h00);
        check("bounce_value_kept", {4'h0, key_value}, 8'h05);
        pressed[2*4+3] = 1'b1;
        exp_q.push_back(4'hC);
        wait_down(1'b1, 60, "pressC_key_down");
        check("pressC_value", {4'h0, key_value}, 8'h0C);
        pressed = '0;
        wait_down(1'b0, 20, "pressC_release");

        // Rows 0 and 3 together in col 1: lowest row wins -> "2"
        pressed[0*4+1] = 1'b1;
        pressed[3*4+1] = 1'b1;
        exp_q.push_back(4'h2);
        wait_down(1'b1, 60, "two_keys_down");
        check("two_keys_value", {4'h0, key_value}, 8'h02);
        pressed = '0;
        wait_down(1'b0, 20, "two_keys_release");

        // Extra keys while "5" is held must not produce another strobe
        pressed[1*4+1] = 1'b1;
        exp_q.push_back(4'h5);
        wait_down(1'b1, 60, "hold5_key_down");
        pressed[3*4+2] = 1'b1;
        pressed[0*4+1] = 1'b1;
        repeat (20) @(negedge clk);
        check("hold5_still_down", {7'h0, key_down},  8'h01);
        check("hold5_value",      {4'h0, key_value}, 8'h05);
        pressed = '0;
        wait_down(1'b0, 20, "hold5_release");

        // Reset during press debounce: key "9" aborted at count 5
        wait_col(4'b1011);
        pressed[2*4+2] = 1'b1;
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_col",       {4'h0, col},       8'h0E);
        check("midrst_key_value", {4'h0, key_value}, 8'h00);
        check("midrst_key_valid", {7'h0, key_valid}, 8'h00);
        check("midrst_key_down",  {7'h0, key_down},  8'h00);
        pressed = '0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        check("midrst_no_key_down", {7'h0, key_down}, 8'h00);

        check("scoreboard_empty", 8'(exp_q.size()), 8'h00);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
